ddr_rd_arbiter: RTL and testbench

- Round-robin arbiter sharing the single DDR read-burst port between NUM_REQ burst requesters.
- Requesters are the weight FIFO (Q/K/V/MLP weights), the fmap/spike loader and the parameter loader.
- Each requester keeps its existing req/addr/len/valid/finish burst protocol; the arbiter looks like the DDR controller to them.
- Exactly one burst is outstanding at a time.

---
 rtl/ddr_rd_arbiter.sv | 176 +++++++++++++++++
 tb/tb_ddr_rd_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rd_arbiter.sv
// rtl/ddr_rd_arbiter.sv - round-robin arbiter sharing one DDR read-burst port between NUM_REQ requesters
// Optional beat/length checker enabled by DDR_ARB_BEAT_CHECK_EN (adds o_len_err).

module ddr_rd_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_SIZE  = 32,
  parameter int LEN_WIDTH  = 10,
  parameter int DATA_WIDTH = 64
) (
  input  logic                         s_clk,
  input  logic                         s_rst,
  input  logic [NUM_REQ-1:0]           s_rd_burst_req,
  input  logic [NUM_REQ*ADDR_SIZE-1:0] s_rd_burst_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0] s_rd_burst_len,
  output logic [DATA_WIDTH-1:0]        s_rd_burst_data,
  output logic [NUM_REQ-1:0]           s_rd_burst_valid,
  output logic [NUM_REQ-1:0]           s_rd_burst_finish,
  output logic                         m_rd_burst_req,
  output logic [ADDR_SIZE-1:0]         m_rd_burst_addr,
  output logic [LEN_WIDTH-1:0]         m_rd_burst_len,
  input  logic [DATA_WIDTH-1:0]        m_rd_burst_data,
  input  logic                         m_rd_burst_valid,
  input  logic                         m_rd_burst_finish,
  output logic [NUM_REQ-1:0]           o_grant,
  output logic                         o_busy
`ifdef DDR_ARB_BEAT_CHECK_EN
  ,
  output logic                         o_len_err
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 m_req_q, m_req_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;

  logic                 win_found;
  logic [PTR_W-1:0]     win_idx;
  logic [PTR_W:0]       cand_sum;
  logic [PTR_W:0]       nxt_sum;

  // Search starts at rr_ptr and wraps; the extra sum bit keeps the wrap exact for any NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_sum  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (cand_sum >= (PTR_W+1)'(NUM_REQ)) begin
        cand_sum = cand_sum - (PTR_W+1)'(NUM_REQ);
      end
      if (!win_found && s_rd_burst_req[cand_sum[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand_sum[PTR_W-1:0];
      end
    end
    nxt_sum = {1'b0, win_idx} + (PTR_W+1)'(1);
    if (nxt_sum == (PTR_W+1)'(NUM_REQ)) begin
      nxt_sum = '0;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    m_req_d  = m_req_q;
    addr_d   = addr_q;
    len_d    = len_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d          = ST_ISSUE;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          m_req_d          = 1'b1;
          addr_d           = s_rd_burst_addr[int'(win_idx)*ADDR_SIZE +: ADDR_SIZE];
          len_d            = s_rd_burst_len[int'(win_idx)*LEN_WIDTH +: LEN_WIDTH];
          rr_ptr_d         = nxt_sum[PTR_W-1:0];
        end
      end
      ST_ISSUE: begin
        if (m_rd_burst_finish) begin
          state_d = ST_DONE;
          m_req_d = 1'b0;
          grant_d = '0;
        end
      end
      // One dead cycle hides the requester's req, which is still high the cycle after finish.
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        m_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      m_req_q  <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      m_req_q  <= m_req_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
    end
  end

  assign s_rd_burst_data   = m_rd_burst_data;
  assign s_rd_burst_valid  = {NUM_REQ{m_rd_burst_valid}} & grant_q;
  assign s_rd_burst_finish = {NUM_REQ{m_rd_burst_finish}} & grant_q;
  assign m_rd_burst_req    = m_req_q;
  assign m_rd_burst_addr   = addr_q;
  assign m_rd_burst_len    = len_q;
  assign o_grant           = grant_q;
  assign o_busy            = (state_q != ST_IDLE);

`ifdef DDR_ARB_BEAT_CHECK_EN
  logic [LEN_WIDTH:0] cnt_q, cnt_d;
  logic [LEN_WIDTH:0] cnt_fin;
  logic [LEN_WIDTH:0] len_ext;
  logic               len_err_q, len_err_d;

  // A beat coincident with finish still counts toward the burst length.
  always_comb begin
    cnt_d     = cnt_q;
    len_err_d = len_err_q;
    len_ext   = {1'b0, len_q};
    cnt_fin   = cnt_q + {{LEN_WIDTH{1'b0}}, m_rd_burst_valid};
    if (state_q == ST_IDLE && win_found) begin
      cnt_d = '0;
    end else if (state_q == ST_ISSUE) begin
      if (m_rd_burst_valid) begin
        if (cnt_q == len_ext) begin
          len_err_d = 1'b1;
        end
        cnt_d = cnt_q + (LEN_WIDTH+1)'(1);
      end
      if (m_rd_burst_finish && (cnt_fin != len_ext)) begin
        len_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      cnt_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      len_err_q <= len_err_d;
    end
  end

  assign o_len_err = len_err_q;
`endif

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// tb/tb_ddr_rd_arbiter.sv - self-checking bench for ddr_rd_arbiter (vector table + beat scoreboard)
// Exercises the DDR_ARB_BEAT_CHECK_EN checker when that macro is defined.

module tb_ddr_rd_arbiter;

  localparam int NR = 3;
  localparam int AW = 32;
  localparam int LW = 10;
  localparam int DW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              s_rst;
  logic [NR-1:0]     s_rd_burst_req;
  logic [NR*AW-1:0]  s_rd_burst_addr;
  logic [NR*LW-1:0]  s_rd_burst_len;
  logic [DW-1:0]     s_rd_burst_data;
  logic [NR-1:0]     s_rd_burst_valid;
  logic [NR-1:0]     s_rd_burst_finish;
  logic              m_rd_burst_req;
  logic [AW-1:0]     m_rd_burst_addr;
  logic [LW-1:0]     m_rd_burst_len;
  logic [DW-1:0]     m_rd_burst_data;
  logic              m_rd_burst_valid;
  logic              m_rd_burst_finish;
  logic [NR-1:0]     o_grant;
  logic              o_busy;
`ifdef DDR_ARB_BEAT_CHECK_EN
  logic              o_len_err;
`endif

  logic [AW-1:0] req_addr [NR];
  logic [LW-1:0] req_len  [NR];

  assign s_rd_burst_addr = {req_addr[2], req_addr[1], req_addr[0]};
  assign s_rd_burst_len  = {req_len[2], req_len[1], req_len[0]};

  ddr_rd_arbiter #(.NUM_REQ(NR), .ADDR_SIZE(AW), .LEN_WIDTH(LW), .DATA_WIDTH(DW)) dut (
    .s_clk             (clk),
    .s_rst             (s_rst),
    .s_rd_burst_req    (s_rd_burst_req),
    .s_rd_burst_addr   (s_rd_burst_addr),
    .s_rd_burst_len    (s_rd_burst_len),
    .s_rd_burst_data   (s_rd_burst_data),
    .s_rd_burst_valid  (s_rd_burst_valid),
    .s_rd_burst_finish (s_rd_burst_finish),
    .m_rd_burst_req    (m_rd_burst_req),
    .m_rd_burst_addr   (m_rd_burst_addr),
    .m_rd_burst_len    (m_rd_burst_len),
    .m_rd_burst_data   (m_rd_burst_data),
    .m_rd_burst_valid  (m_rd_burst_valid),
    .m_rd_burst_finish (m_rd_burst_finish),
    .o_grant           (o_grant),
    .o_busy            (o_busy)
`ifdef DDR_ARB_BEAT_CHECK_EN
    ,
    .o_len_err         (o_len_err)
`endif
  );

  typedef struct {
    logic [NR-1:0] new_req;
    int            exp_idx;
    int            exp_wait;
  } vec_t;

  typedef struct {
    int          idx;
    logic [DW-1:0] data;
  } beat_t;

  beat_t sb[$];
  vec_t  vecs[7];
  int    tests = 0;
  int    fails = 0;
  bit    fin_expected = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NR-1:0] oh(input int i);
    oh = NR'(1) << i;
  endfunction

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  // Every beat the DUT hands to a requester must match the oldest driven beat.
  always @(negedge clk) begin
    beat_t e;
    if (s_rd_burst_valid != '0) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL beat_unexpected: valid=%b data=0x%0h, expected no beat", s_rd_burst_valid, s_rd_burst_data);
      end else begin
        e = sb.pop_front();
        if (s_rd_burst_valid !== oh(e.idx) || s_rd_burst_data !== e.data) begin
          fails++;
          $display("FAIL beat: valid=%b data=0x%0h, expected valid=%b data=0x%0h",
                   s_rd_burst_valid, s_rd_burst_data, oh(e.idx), e.data);
        end
      end
    end
    if (s_rd_burst_finish != '0 && !fin_expected) begin
      tests++;
      fails++;
      $display("FAIL finish_unexpected: finish=%b, expected 000", s_rd_burst_finish);
    end
  end

  // Returns at the negedge where m_rd_burst_req is high; counts low cycles and idle cycles before it.
  task automatic await_req(output int waited, output int idle_cyc);
    waited   = -1;
    idle_cyc = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (m_rd_burst_req) begin
        waited = n;
        break;
      end
      if (!o_busy) idle_cyc++;
      drv();
    end
    if (waited < 0) begin
      tests++;
      fails++;
      $display("FAIL await_req: m_rd_burst_req still 0 after 20 cycles, expected 1");
      @(negedge clk);
    end
  endtask

  // Called at a drive point; drives nbeats then a finish pulse, returns at the drive point of DONE.
  task automatic serve(input int idx, input int nbeats, input logic [AW-1:0] exp_addr, input logic [LW-1:0] exp_len);
    beat_t e;
    for (int b = 0; b < nbeats; b++) begin
      e.idx  = idx;
      e.data = {$urandom, $urandom};
      m_rd_burst_data  = e.data;
      m_rd_burst_valid = 1'b1;
      sb.push_back(e);
      @(negedge clk);
      check("hold_addr", m_rd_burst_addr, exp_addr);
      check("hold_len", m_rd_burst_len, exp_len);
      check("hold_req", m_rd_burst_req, 1);
      drv();
    end
    m_rd_burst_valid  = 1'b0;
    m_rd_burst_finish = 1'b1;
    fin_expected      = 1'b1;
    @(negedge clk);
    check("finish_pulse", s_rd_burst_finish, oh(idx));
    drv();
    m_rd_burst_finish = 1'b0;
    fin_expected      = 1'b0;
  endtask

  task automatic episode(input int idx, input int exp_wait);
    int w, ic;
    await_req(w, ic);
    check("grant_wait", w, exp_wait);
    check("grant", o_grant, oh(idx));
    check("m_addr", m_rd_burst_addr, req_addr[idx]);
    check("m_len", m_rd_burst_len, req_len[idx]);
    check("busy_issue", o_busy, 1);
    drv();
    serve(idx, int'(req_len[idx]), req_addr[idx], req_len[idx]);
    @(negedge clk);
    check("done_req", m_rd_burst_req, 0);
    check("done_grant", o_grant, 0);
    check("done_busy", o_busy, 1);
    drv();
    s_rd_burst_req[idx] = 1'b0;
    @(negedge clk);
    check("idle_busy", o_busy, 0);
    check("idle_req", m_rd_burst_req, 0);
    drv();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w, ic;
    beat_t e;
    vecs[0] = '{3'b001, 0, 1};
    vecs[1] = '{3'b010, 1, 1};
    vecs[2] = '{3'b101, 2, 1};
    vecs[3] = '{3'b000, 0, 0};
    vecs[4] = '{3'b111, 1, 1};
    vecs[5] = '{3'b000, 2, 0};
    vecs[6] = '{3'b000, 0, 0};

    req_addr[0] = 32'h0000_1000; req_len[0] = 10'd8;
    req_addr[1] = 32'h4000_0040; req_len[1] = 10'd3;
    req_addr[2] = 32'hFFFF_FFC0; req_len[2] = 10'd1;

    s_rst             = 1'b1;
    s_rd_burst_req    = '0;
    m_rd_burst_data   = '0;
    m_rd_burst_valid  = 1'b0;
    m_rd_burst_finish = 1'b0;
    drv();
    drv();
    @(negedge clk);
    check("rst_m_req", m_rd_burst_req, 0);
    check("rst_m_addr", m_rd_burst_addr, 0);
    check("rst_m_len", m_rd_burst_len, 0);
    check("rst_grant", o_grant, 0);
    check("rst_busy", o_busy, 0);
    drv();
    s_rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      s_rd_burst_req = s_rd_burst_req | vecs[v].new_req;
      episode(vecs[v].exp_idx, vecs[v].exp_wait);
    end

    // Address/len changes and a dropped req after grant must not disturb the burst.
    s_rd_burst_req[0] = 1'b1;
    await_req(w, ic);
    check("latch_grant", o_grant, 3'b001);
    check("latch_addr0", m_rd_burst_addr, 32'h0000_1000);
    drv();
    req_addr[0]       = 32'h0000_2000;
    req_len[0]        = 10'd3;
    s_rd_burst_req[0] = 1'b0;
    serve(0, 8, 32'h0000_1000, 10'd8);
    @(negedge clk);
    check("latch_done_grant", o_grant, 0);
    drv();
    @(negedge clk);
    check("latch_idle_req", m_rd_burst_req, 0);
    drv();
    req_addr[0] = 32'h0000_1000;
    req_len[0]  = 10'd8;

    // All three held continuously from reset.
    s_rst          = 1'b1;
    s_rd_burst_req = '1;
    drv();
    s_rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      await_req(w, ic);
      check("rr_grant", o_grant, oh(k % 3));
      check("rr_gap", w, (k == 0) ? 1 : 2);
      check("rr_idle_cycles", ic, 1);
      drv();
      serve(k % 3, int'(req_len[k % 3]), req_addr[k % 3], req_len[k % 3]);
    end
    s_rd_burst_req = '0;
    drv();
    drv();

    // Reset after beat 3 of 8: remaining beats and finish must reach nobody.
    s_rd_burst_req[0] = 1'b1;
    await_req(w, ic);
    check("mid_grant", o_grant, 3'b001);
    drv();
    for (int b = 0; b < 3; b++) begin
      e.idx  = 0;
      e.data = {$urandom, $urandom};
      m_rd_burst_data  = e.data;
      m_rd_burst_valid = 1'b1;
      sb.push_back(e);
      @(negedge clk);
      drv();
    end
    m_rd_burst_valid = 1'b0;
    s_rst            = 1'b1;
    s_rd_burst_req   = '0;
    @(negedge clk);
    drv();
    s_rst = 1'b0;
    @(negedge clk);
    check("mid_rst_req", m_rd_burst_req, 0);
    check("mid_rst_grant", o_grant, 0);
    check("mid_rst_busy", o_busy, 0);
    for (int b = 0; b < 5; b++) begin
      drv();
      m_rd_burst_data  = {$urandom, $urandom};
      m_rd_burst_valid = 1'b1;
      @(negedge clk);
      check("mid_tail_req", m_rd_burst_req, 0);
      check("mid_tail_grant", o_grant, 0);
    end
    drv();
    m_rd_burst_valid  = 1'b0;
    m_rd_burst_finish = 1'b1;
    @(negedge clk);
    check("mid_tail_finish", s_rd_burst_finish, 0);
    drv();
    m_rd_burst_finish = 1'b0;

`ifdef DDR_ARB_BEAT_CHECK_EN
    s_rst = 1'b1;
    drv();
    s_rst = 1'b0;
    @(negedge clk);
    check("len_err_reset", o_len_err, 0);
    drv();
    s_rd_burst_req[0] = 1'b1;
    episode(0, 1);
    @(negedge clk);
    check("len_err_good_burst", o_len_err, 0);
    drv();
    s_rd_burst_req[0] = 1'b1;
    await_req(w, ic);
    drv();
    serve(0, 7, 32'h0000_1000, 10'd8);
    @(negedge clk);
    check("len_err_short", o_len_err, 1);
    drv();
    s_rd_burst_req[0] = 1'b0;
    @(negedge clk);
    drv();
    s_rd_burst_req[0] = 1'b1;
    episode(0, 1);
    @(negedge clk);
    check("len_err_sticky", o_len_err, 1);
    drv();
    s_rst = 1'b1;
    drv();
    s_rst = 1'b0;
    @(negedge clk);
    check("len_err_cleared", o_len_err, 0);
    drv();
`endif

    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
